// File: rtl/spi_tx_fifo_master.sv
// spi_tx_fifo_master: FIFO-buffered SPI transmit master
// streams {DC,data} words to the SSD1331 OLED pins
module spi_tx_fifo_master #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 0,
  parameter int CPOL      = 0,
  parameter int CS_GAP    = 1
) (
  input  logic                     i_SCK,
  input  logic                     i_RST,
  input  logic [WIDTH-1:0]         i_DATA,
  input  logic                     i_DC,
  input  logic                     i_WR,
  output logic                     o_FULL,
  output logic                     o_EMPTY,
  output logic [$clog2(DEPTH):0]   o_LEVEL,
  output logic                     o_OVF,
  output logic                     o_SCLK,
  output logic                     o_MOSI,
  output logic                     o_CS,
  output logic                     o_DC,
  output logic                     o_BUSY,
  output logic                     o_DONE
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int BW   = $clog2(WIDTH);
  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] H_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] G_LAST = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  logic [WIDTH:0]   mem [DEPTH];
  logic [LW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH:0]   head;
  logic             push, pop;

  state_t           state, nx_state;
  logic [CW-1:0]    div_cnt, nx_div;
  logic [BW-1:0]    bit_cnt, nx_bit;
  logic             phase_b, nx_phase_b;
  logic [WIDTH-1:0] sr, nx_sr, shifted;
  logic             sclk, nx_sclk;
  logic             mosi, nx_mosi;
  logic             cs, nx_cs;
  logic             dc, nx_dc;
  logic             done, nx_done;
  logic             ovf, nx_ovf;
  logic             busy;
  logic             load;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  assign o_LEVEL = wr_ptr - rd_ptr;
  assign o_FULL  = (o_LEVEL == LW'(DEPTH));
  assign o_EMPTY = (o_LEVEL == '0);
  assign push    = i_WR & ~o_FULL;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign shifted = (LSB_FIRST != 0) ? (sr >> 1) : (sr << 1);

  // FIFO storage; reset flushes through the pointers only
  always_ff @(posedge i_SCK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {i_DC, i_DATA};
  end

  // FIFO pointers, one extra bit so full and empty differ
  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // next-state and next-output logic for the transmit sequencer
  always_comb begin
    nx_state   = state;
    nx_div     = div_cnt;
    nx_bit     = bit_cnt;
    nx_phase_b = phase_b;
    nx_sr      = sr;
    nx_sclk    = sclk;
    nx_mosi    = mosi;
    nx_cs      = cs;
    nx_dc      = dc;
    nx_done    = 1'b0;
    nx_ovf     = i_WR & o_FULL;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        nx_cs   = 1'b1;
        nx_sclk = IDLE_LVL;
        if (!o_EMPTY) load = 1'b1;
      end
      SHIFT: begin
        if (div_cnt == H_LAST) begin
          nx_div = '0;
          if (!phase_b) begin
            nx_phase_b = 1'b1;
            nx_sclk    = 1'b1;
          end else if (bit_cnt == B_LAST) begin
            nx_done = 1'b1;
            if (!o_EMPTY) begin
              load = 1'b1;
            end else begin
              nx_state = HOLD;
              nx_sclk  = IDLE_LVL;
            end
          end else begin
            nx_phase_b = 1'b0;
            nx_sclk    = 1'b0;
            nx_bit     = bit_cnt + 1'b1;
            nx_sr      = shifted;
            nx_mosi    = first_bit(shifted);
          end
        end else begin
          nx_div = div_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (div_cnt == H_LAST) begin
          nx_div   = '0;
          nx_cs    = 1'b1;
          nx_state = GAP;
        end else begin
          nx_div = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == G_LAST) begin
          nx_div   = '0;
          nx_state = IDLE;
        end else begin
          nx_div = div_cnt + 1'b1;
        end
      end
      default: nx_state = IDLE;
    endcase
    if (load) begin
      nx_sr      = head[WIDTH-1:0];
      nx_dc      = head[WIDTH];
      nx_mosi    = first_bit(head[WIDTH-1:0]);
      nx_cs      = 1'b0;
      nx_sclk    = 1'b0;
      nx_div     = '0;
      nx_bit     = '0;
      nx_phase_b = 1'b0;
      nx_state   = SHIFT;
    end
  end

  assign pop = load;

  // state and registered outputs
  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase_b <= 1'b0;
      sr      <= '0;
      sclk    <= IDLE_LVL;
      mosi    <= 1'b0;
      cs      <= 1'b1;
      dc      <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nx_state;
      div_cnt <= nx_div;
      bit_cnt <= nx_bit;
      phase_b <= nx_phase_b;
      sr      <= nx_sr;
      sclk    <= nx_sclk;
      mosi    <= nx_mosi;
      cs      <= nx_cs;
      dc      <= nx_dc;
      done    <= nx_done;
      ovf     <= nx_ovf;
      busy    <= (nx_state != IDLE);
    end
  end

  assign o_SCLK = sclk;
  assign o_MOSI = mosi;
  assign o_CS   = cs;
  assign o_DC   = dc;
  assign o_DONE = done;
  assign o_OVF  = ovf;
  assign o_BUSY = busy;

endmodule

// File: tb/tb_spi_tx_fifo_master.sv
// tb_spi_tx_fifo_master: two configurations checked against
// a timeline model plus hand-computed expectations
module tb_spi_tx_fifo_master;

  logic clk = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   chk_en = 1'b0;

  logic       rst0 = 1'b1, wr0 = 1'b0, dc0 = 1'b0;
  logic [7:0] data0 = '0;
  logic       full0, empty0, ovf0, sclk0, mosi0, cs0, dco0, busy0, done0;
  logic [2:0] level0;

  logic       rst1 = 1'b1, wr1 = 1'b0, dc1 = 1'b0;
  logic [4:0] data1 = '0;
  logic       full1, empty1, ovf1, sclk1, mosi1, cs1, dco1, busy1, done1;
  logic [2:0] level1;

  spi_tx_fifo_master #(
    .WIDTH(8), .DEPTH(4), .CLK_DIV(2),
    .LSB_FIRST(0), .CPOL(0), .CS_GAP(1)
  ) u0 (
    .i_SCK(clk), .i_RST(rst0), .i_DATA(data0), .i_DC(dc0),
    .i_WR(wr0), .o_FULL(full0), .o_EMPTY(empty0),
    .o_LEVEL(level0), .o_OVF(ovf0), .o_SCLK(sclk0),
    .o_MOSI(mosi0), .o_CS(cs0), .o_DC(dco0),
    .o_BUSY(busy0), .o_DONE(done0)
  );

  spi_tx_fifo_master #(
    .WIDTH(5), .DEPTH(4), .CLK_DIV(1),
    .LSB_FIRST(1), .CPOL(1), .CS_GAP(2)
  ) u1 (
    .i_SCK(clk), .i_RST(rst1), .i_DATA(data1), .i_DC(dc1),
    .i_WR(wr1), .o_FULL(full1), .o_EMPTY(empty1),
    .o_LEVEL(level1), .o_OVF(ovf1), .o_SCLK(sclk1),
    .o_MOSI(mosi1), .o_CS(cs1), .o_DC(dco1),
    .o_BUSY(busy1), .o_DONE(done1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int pw(int k);   return k ? 5 : 8; endfunction
  function automatic int ph(int k);   return k ? 1 : 2; endfunction
  function automatic int plsb(int k); return k ? 1 : 0; endfunction
  function automatic int pcp(int k);  return k ? 1 : 0; endfunction
  function automatic int pg(int k);   return k ? 2 : 1; endfunction

  // mode: 0 idle, 1 transferring, 2 cs hold, 3 cs gap
  int m_mode[2], m_t[2], m_u[2], m_cnt[2], m_head[2];
  int m_cur[2], m_curdc[2], m_mosi[2], m_done[2], m_ovf[2];
  int m_q[2][4], m_qd[2][4];

  task automatic model_pop(input int k);
    m_cur[k]   = m_q[k][m_head[k]];
    m_curdc[k] = m_qd[k][m_head[k]];
    m_head[k]  = (m_head[k] + 1) % 4;
    m_cnt[k]--;
    m_t[k]     = 0;
    m_mode[k]  = 1;
  endtask

  task automatic model_step(input int k, input logic rst,
                            input logic wr, input int data,
                            input logic dc);
    bit full_pre;
    int b;
    if (rst) begin
      m_mode[k] = 0; m_t[k] = 0; m_u[k] = 0; m_cnt[k] = 0;
      m_head[k] = 0; m_curdc[k] = 0; m_mosi[k] = 0;
      m_done[k] = 0; m_ovf[k] = 0;
      return;
    end
    full_pre  = (m_cnt[k] == 4);
    m_done[k] = 0;
    m_ovf[k]  = 0;
    case (m_mode[k])
      0: if (m_cnt[k] > 0) model_pop(k);
      1: begin
        m_t[k]++;
        if (m_t[k] == pw(k) * 2 * ph(k)) begin
          m_done[k] = 1;
          if (m_cnt[k] > 0) model_pop(k);
          else begin m_mode[k] = 2; m_u[k] = 0; end
        end
      end
      2: begin
        m_u[k]++;
        if (m_u[k] == ph(k)) begin m_mode[k] = 3; m_u[k] = 0; end
      end
      default: begin
        m_u[k]++;
        if (m_u[k] == pg(k)) m_mode[k] = 0;
      end
    endcase
    if (wr) begin
      if (full_pre) m_ovf[k] = 1;
      else begin
        m_q[k][(m_head[k] + m_cnt[k]) % 4]  = data;
        m_qd[k][(m_head[k] + m_cnt[k]) % 4] = dc;
        m_cnt[k]++;
      end
    end
    if (m_mode[k] == 1) begin
      b = m_t[k] / (2 * ph(k));
      if (plsb(k) != 0) m_mosi[k] = (m_cur[k] >> b) & 1;
      else m_mosi[k] = (m_cur[k] >> (pw(k) - 1 - b)) & 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0, rst0, wr0, int'(data0), dc0);
    model_step(1, rst1, wr1, int'(data1), dc1);
  end

  task automatic cmp(input int k, input logic cs, input logic sclk,
                     input logic mosi, input logic dc,
                     input logic busy, input logic done,
                     input logic ovf, input logic full,
                     input logic empty, input logic [31:0] level);
    int ecs, esclk;
    ecs = (m_mode[k] == 0 || m_mode[k] == 3) ? 1 : 0;
    if (m_mode[k] == 1)
      esclk = ((m_t[k] % (2 * ph(k))) >= ph(k)) ? 1 : 0;
    else
      esclk = pcp(k);
    chk($sformatf("cs%0d", k), cs, ecs);
    chk($sformatf("sclk%0d", k), sclk, esclk);
    chk($sformatf("mosi%0d", k), mosi, m_mosi[k]);
    chk($sformatf("dc%0d", k), dc, m_curdc[k]);
    chk($sformatf("busy%0d", k), busy, (m_mode[k] != 0) ? 1 : 0);
    chk($sformatf("done%0d", k), done, m_done[k]);
    chk($sformatf("ovf%0d", k), ovf, m_ovf[k]);
    chk($sformatf("full%0d", k), full, (m_cnt[k] == 4) ? 1 : 0);
    chk($sformatf("empty%0d", k), empty, (m_cnt[k] == 0) ? 1 : 0);
    chk($sformatf("level%0d", k), level, m_cnt[k]);
  endtask

  int falls0[$], rises0[$], dones0[$], ovfs0[$], dcchg0[$], bits0[$];
  int falls1[$], dones1[$], bits1[$];
  logic p_cs0, p_sclk0, p_dc0, p_sclk1, p_cs1;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, cs0, sclk0, mosi0, dco0, busy0, done0, ovf0,
          full0, empty0, 32'(level0));
      cmp(1, cs1, sclk1, mosi1, dco1, busy1, done1, ovf1,
          full1, empty1, 32'(level1));
    end
    if (p_cs0 === 1'b1 && cs0 === 1'b0) falls0.push_back(cyc);
    if (p_cs0 === 1'b0 && cs0 === 1'b1) rises0.push_back(cyc);
    if (done0 === 1'b1) dones0.push_back(cyc);
    if (ovf0 === 1'b1) ovfs0.push_back(cyc);
    if (dco0 !== p_dc0) dcchg0.push_back(cyc);
    if (p_sclk0 === 1'b0 && sclk0 === 1'b1) bits0.push_back(int'(mosi0));
    if (p_cs1 === 1'b1 && cs1 === 1'b0) falls1.push_back(cyc);
    if (done1 === 1'b1) dones1.push_back(cyc);
    if (p_sclk1 === 1'b0 && sclk1 === 1'b1) bits1.push_back(int'(mosi1));
    p_cs0 = cs0; p_sclk0 = sclk0; p_dc0 = dco0;
    p_cs1 = cs1; p_sclk1 = sclk1;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_mon();
    falls0.delete(); rises0.delete(); dones0.delete();
    ovfs0.delete(); dcchg0.delete(); bits0.delete();
    falls1.delete(); dones1.delete(); bits1.delete();
  endtask

  task automatic push0(input logic [7:0] d, input logic c,
                       output int e);
    data0 = d; dc0 = c; wr0 = 1'b1;
    @(posedge clk); #2;
    wr0 = 1'b0; e = cyc;
  endtask

  task automatic push1(input logic [4:0] d, input logic c,
                       output int e);
    data1 = d; dc1 = c; wr1 = 1'b1;
    @(posedge clk); #2;
    wr1 = 1'b0; e = cyc;
  endtask

  task automatic wait_idle0(input int max);
    for (int i = 0; i < max && (busy0 || !empty0); i++) step(1);
    chk("idle0_timeout", {31'b0, busy0 | ~empty0}, 0);
  endtask

  task automatic wait_idle1(input int max);
    for (int i = 0; i < max && (busy1 || !empty1); i++) step(1);
    chk("idle1_timeout", {31'b0, busy1 | ~empty1}, 0);
  endtask

  function automatic int msb_val(input int q[$], input int lo,
                                 input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | qget(q, lo + i);
    return v;
  endfunction

  function automatic int lsb_val(input int q[$], input int n);
    int v = 0;
    for (int i = 0; i < n; i++) v = v | (qget(q, i) << i);
    return v;
  endfunction

  int e0, e1;
  int exp3[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    @(posedge clk); #2;
    step(3);
    chk("rst_cs0", cs0, 1);    chk("rst_sclk0", sclk0, 0);
    chk("rst_mosi0", mosi0, 0); chk("rst_dc0", dco0, 0);
    chk("rst_busy0", busy0, 0); chk("rst_done0", done0, 0);
    chk("rst_ovf0", ovf0, 0);   chk("rst_empty0", empty0, 1);
    chk("rst_full0", full0, 0); chk("rst_level0", level0, 0);
    chk("rst_sclk1", sclk1, 1); chk("rst_cs1", cs1, 1);
    chk_en = 1'b1;
    rst0 = 1'b0; rst1 = 1'b0;
    step(2);

    // single word, MSB first
    clear_mon();
    push0(8'hA5, 1'b1, e0);
    chk("s1_empty", empty0, 0);
    wait_idle0(200);
    chk("s1_csfall", qget(falls0, 0), e0 + 1);
    chk("s1_dcrise", qget(dcchg0, 0), e0 + 1);
    chk("s1_nbits", bits0.size(), 8);
    chk("s1_bits", msb_val(bits0, 0, 8), 8'hA5);
    chk("s1_done", qget(dones0, 0), e0 + 33);
    chk("s1_ndone", dones0.size(), 1);
    chk("s1_csrise", qget(rises0, 0), e0 + 35);

    // back-to-back words with DC change
    clear_mon();
    push0(8'h3C, 1'b0, e0);
    push0(8'hF0, 1'b1, e1);
    wait_idle0(300);
    chk("s2_nfall", falls0.size(), 1);
    chk("s2_csfall", qget(falls0, 0), e0 + 1);
    chk("s2_shift", qget(dones0, 1) - qget(falls0, 0), 64);
    chk("s2_dgap", qget(dones0, 1) - qget(dones0, 0), 32);
    chk("s2_dc0", qget(dcchg0, 0), e0 + 1);
    chk("s2_dc1", qget(dcchg0, 1), e0 + 33);
    chk("s2_csrise", qget(rises0, 0), e0 + 67);
    chk("s2_bits", msb_val(bits0, 0, 16), 16'h3CF0);

    // FIFO boundaries with the transmitter busy
    clear_mon();
    push0(8'h11, 1'b0, e0);
    step(3);
    push0(8'h22, 1'b1, e1);
    push0(8'h33, 1'b0, e1);
    push0(8'h44, 1'b1, e1);
    push0(8'h55, 1'b0, e1);
    chk("s3_full", full0, 1);
    chk("s3_level", level0, 4);
    push0(8'h66, 1'b1, e1);
    chk("s3_ovf5", ovf0, 1);
    push0(8'h77, 1'b1, e1);
    chk("s3_ovf6", ovf0, 1);
    while (cyc < e0 + 32) step(1);
    push0(8'h88, 1'b0, e1);
    chk("s3_ovfpop", ovf0, 1);
    chk("s3_lvlpop", level0, 3);
    wait_idle0(600);
    chk("s3_novf", ovfs0.size(), 3);
    chk("s3_ndone", dones0.size(), 5);
    chk("s3_nbits", bits0.size(), 40);
    for (int w = 0; w < 5; w++)
      chk($sformatf("s3_word%0d", w), msb_val(bits0, 8 * w, 8),
          exp3[w]);

    // LSB first, odd width, minimum divide
    clear_mon();
    push1(5'h13, 1'b0, e0);
    wait_idle1(100);
    chk("s4_csfall", qget(falls1, 0), e0 + 1);
    chk("s4_done", qget(dones1, 0), e0 + 11);
    chk("s4_len", qget(dones1, 0) - qget(falls1, 0), 10);
    chk("s4_nbits", bits1.size(), 5);
    chk("s4_bits", lsb_val(bits1, 5), 5'h13);

    // reset during bit 3 with CPOL=1
    push1(5'h0A, 1'b1, e0);
    while (cyc < e0 + 7) step(1);
    chk("s5_mid_cs", cs1, 0);
    rst1 = 1'b1;
    step(1);
    chk("s5_sclk", sclk1, 1);   chk("s5_cs", cs1, 1);
    chk("s5_level", level1, 0); chk("s5_empty", empty1, 1);
    chk("s5_busy", busy1, 0);   chk("s5_mosi", mosi1, 0);
    chk("s5_dc", dco1, 0);      chk("s5_done", done1, 0);
    rst1 = 1'b0;
    step(1);
    clear_mon();
    push1(5'h16, 1'b1, e0);
    wait_idle1(100);
    chk("s5_csfall", qget(falls1, 0), e0 + 1);
    chk("s5_done2", qget(dones1, 0), e0 + 11);
    chk("s5_bits", lsb_val(bits1, 5), 5'h16);
    chk("s5_nbits", bits1.size(), 5);

    step(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
